// File: rtl/keccak_round_sequencer.sv
// Keccak-f[1600] round sequencer: drives CP -> ROT -> PERM -> REV -> ARC each round with
// one-cycle init pulses and stable indices, waiting on step handshakes under a watchdog.
`timescale 1ns/1ps
module keccak_round_sequencer #(
  parameter int ROUNDS  = 24,
  parameter int SLICES  = 64,
  parameter int LANES   = 25,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       colparIJrster,
  input  logic       colparDone,
  output logic       initRotate,
  input  logic       finishLane,
  output logic       initLine,
  input  logic       permDone,
  output logic       initReval,
  input  logic       revalDone,
  output logic       initARC,
  output logic [5:0] sliceNum,
  output logic [4:0] sliceIdx,
  output logic [4:0] roundIdx,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [3:0] {
    IDLE, CP_INIT, CP_WAIT, ROT_INIT, ROT_WAIT, PERM_INIT, PERM_WAIT,
    REV_INIT, REV_WAIT, ARC, DONE, ERROR
  } state_t;

  localparam logic [5:0] SLICE_LAST = 6'(SLICES - 1);
  localparam logic [4:0] LANE_LAST  = 5'(LANES - 1);
  localparam logic [4:0] ROUND_LAST = 5'(ROUNDS - 1);
  localparam logic [7:0] WD_LIMIT   = 8'(TIMEOUT);

  state_t     state_reg, state_next;
  logic [5:0] slice_reg, slice_next;
  logic [4:0] lane_reg, lane_next;
  logic [4:0] round_reg, round_next;
  logic [7:0] wd_reg, wd_next;
  logic       error_reg, error_next;
  logic       wd_tick;
  logic [7:0] wd_inc;

  assign wd_inc = wd_reg + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      slice_reg <= '0;
      lane_reg  <= '0;
      round_reg <= '0;
      wd_reg    <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      slice_reg <= slice_next;
      lane_reg  <= lane_next;
      round_reg <= round_next;
      wd_reg    <= wd_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    slice_next = slice_reg;
    lane_next  = lane_reg;
    round_next = round_reg;
    wd_next    = wd_reg;
    error_next = error_reg;
    wd_tick    = 1'b0;
    if (abort) begin
      // error is sticky across abort; only start or rst clear it
      state_next = IDLE;
      slice_next = '0;
      lane_next  = '0;
      round_next = '0;
      wd_next    = '0;
    end else begin
      case (state_reg)
        IDLE, ERROR: begin
          if (start) begin
            state_next = CP_INIT;
            slice_next = '0;
            lane_next  = '0;
            round_next = '0;
            wd_next    = '0;
            error_next = 1'b0;
          end
        end
        CP_INIT: begin
          state_next = CP_WAIT;
          wd_next    = '0;
        end
        CP_WAIT: begin
          if (colparDone) begin
            if (slice_reg == SLICE_LAST) begin
              slice_next = '0;
              state_next = ROT_INIT;
            end else begin
              slice_next = slice_reg + 6'd1;
              state_next = CP_INIT;
            end
          end else begin
            wd_tick = 1'b1;
          end
        end
        ROT_INIT: begin
          state_next = ROT_WAIT;
          wd_next    = '0;
        end
        ROT_WAIT: begin
          if (finishLane) begin
            if (lane_reg == LANE_LAST) begin
              lane_next  = '0;
              state_next = PERM_INIT;
            end else begin
              lane_next  = lane_reg + 5'd1;
              state_next = ROT_INIT;
            end
          end else begin
            wd_tick = 1'b1;
          end
        end
        PERM_INIT: begin
          state_next = PERM_WAIT;
          wd_next    = '0;
        end
        PERM_WAIT: begin
          if (permDone) begin
            if (slice_reg == SLICE_LAST) begin
              slice_next = '0;
              state_next = REV_INIT;
            end else begin
              slice_next = slice_reg + 6'd1;
              state_next = PERM_INIT;
            end
          end else begin
            wd_tick = 1'b1;
          end
        end
        REV_INIT: begin
          state_next = REV_WAIT;
          wd_next    = '0;
        end
        REV_WAIT: begin
          if (revalDone) begin
            if (slice_reg == SLICE_LAST) begin
              slice_next = '0;
              state_next = ARC;
            end else begin
              slice_next = slice_reg + 6'd1;
              state_next = REV_INIT;
            end
          end else begin
            wd_tick = 1'b1;
          end
        end
        ARC: begin
          if (round_reg == ROUND_LAST) begin
            state_next = DONE;
          end else begin
            round_next = round_reg + 5'd1;
            state_next = CP_INIT;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
      // any WAIT cycle without its handshake ages the watchdog
      if (wd_tick) begin
        wd_next = wd_inc;
        if (wd_inc == WD_LIMIT) begin
          state_next = ERROR;
          error_next = 1'b1;
        end
      end
    end
  end

  assign colparIJrster = (state_reg == CP_INIT);
  assign initRotate    = (state_reg == ROT_INIT);
  assign initLine      = (state_reg == PERM_INIT);
  assign initReval     = (state_reg == REV_INIT);
  assign initARC       = (state_reg == ARC);
  assign busy          = (state_reg != IDLE) && (state_reg != ERROR) && (state_reg != DONE);
  assign done          = (state_reg == DONE);
  assign error         = error_reg;
  assign sliceNum      = slice_reg;
  assign sliceIdx      = lane_reg;
  assign roundIdx      = round_reg;

endmodule
